// File: rtl/ysyx_22040237_mc_ctrl.sv
// ysyx_22040237_mc_ctrl: multi-cycle fetch/decode/execute/memory/writeback sequencer owning PC, IR and instret
module ysyx_22040237_mc_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] inst_o,
    input  logic        dec_is_load,
    input  logic        dec_is_store,
    input  logic        dec_rd_w_en,
    input  logic        dec_is_ebreak,
    input  logic [63:0] next_pc,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_we,
    input  logic        dmem_rsp_valid,
    output logic        rf_w_en,
    output logic [63:0] pc_o,
    output logic [63:0] instret_o,
    output logic        halt,
    output logic [2:0]  state_o
);
    typedef enum logic [2:0] {
        F_REQ  = 3'd0,
        F_WAIT = 3'd1,
        DEC    = 3'd2,
        EXE    = 3'd3,
        M_REQ  = 3'd4,
        M_WAIT = 3'd5,
        WB     = 3'd6,
        HALT   = 3'd7
    } state_t;

    state_t state, state_nx;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= F_REQ;
        else     state <= state_nx;
    end

    // next-state selection; HALT is absorbing until reset
    always_comb begin
        state_nx = state;
        case (state)
            F_REQ:   state_nx = imem_req_ready ? F_WAIT : F_REQ;
            F_WAIT:  state_nx = imem_rsp_valid ? DEC : F_WAIT;
            DEC:     state_nx = EXE;
            EXE:     state_nx = dec_is_ebreak ? HALT : (dec_is_load | dec_is_store) ? M_REQ : WB;
            M_REQ:   state_nx = dmem_req_ready ? M_WAIT : M_REQ;
            M_WAIT:  state_nx = dmem_rsp_valid ? WB : M_WAIT;
            WB:      state_nx = F_REQ;
            default: state_nx = HALT;
        endcase
    end

    // architectural registers: IR captured on fetch response, PC and instret advance on retire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_o      <= RESET_PC;
            inst_o    <= NOP_INST;
            instret_o <= '0;
        end else begin
            if (state == F_WAIT && imem_rsp_valid) inst_o <= imem_rsp_data;
            if (state == WB) begin
                pc_o      <= next_pc;
                instret_o <= instret_o + 64'd1;
            end
        end
    end

    // Moore outputs; request valids and write enable are also gated by rst directly
    assign imem_req_valid = (state == F_REQ) & ~rst;
    assign dmem_req_valid = (state == M_REQ) & ~rst;
    assign dmem_we        = (state == M_REQ) & dec_is_store & ~dec_is_load;
    assign rf_w_en        = (state == WB) & dec_rd_w_en & ~dec_is_store & ~rst;
    assign imem_addr      = pc_o;
    assign halt           = (state == HALT);
    assign state_o        = state;
endmodule

// File: doc/ysyx_22040237_mc_ctrl.md
# ysyx_22040237_mc_ctrl

Multi-cycle sequencing controller for the RV64 core. It owns the PC, instruction register and retired-instruction counter. It steps the existing IFU/IDU/EXU/register-file datapath through fetch, decode, execute, memory and writeback. Instruction and data memories are reached over valid/ready request channels with separate response valids. It replaces the free-running fetch of the single-cycle top.

## Interface
Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction-register value loaded on reset (addi x0,x0,0).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  fetch request accepted.
- imem_addr  out  64  fetch address, equals pc_o.
- imem_rsp_valid  in  1  fetch data valid.
- imem_rsp_data  in  32  fetched instruction.
- inst_o  out  32  instruction register, feeds IDU.
- dec_is_load  in  1  IDU: current instruction is a load.
- dec_is_store  in  1  IDU: current instruction is a store.
- dec_rd_w_en  in  1  IDU: instruction writes rd.
- dec_is_ebreak  in  1  IDU: instruction is ebreak.
- next_pc  in  64  EXU: next PC value for the current instruction.
- dmem_req_valid  out  1  data request valid.
- dmem_req_ready  in  1  data request accepted.
- dmem_we  out  1  data request is a write.
- dmem_rsp_valid  in  1  data read-data / write-ack valid.
- rf_w_en  out  1  register-file write enable (one-cycle pulse).
- pc_o  out  64  current PC.
- instret_o  out  64  retired-instruction count.
- halt  out  1  core halted.
- state_o  out  3  FSM state, for debug.

## Operation
- State encoding: F_REQ=0, F_WAIT=1, DEC=2, EXE=3, M_REQ=4, M_WAIT=5, WB=6, HALT=7. All 8 codes are legal.
- F_REQ: imem_req_valid=1. On imem_req_ready, go to F_WAIT. imem_rsp_valid is ignored in this state.
- F_WAIT: on imem_rsp_valid, inst_o <= imem_rsp_data and go to DEC.
- DEC: one cycle; IDU flags settle from inst_o. Go to EXE.
- EXE: decisions are made in this priority order.
  - dec_is_ebreak: go to HALT.
  - dec_is_load or dec_is_store: go to M_REQ.
  - Otherwise: go to WB.
- M_REQ: dmem_req_valid=1 and dmem_we = dec_is_store & ~dec_is_load (load wins if both are set). On dmem_req_ready, go to M_WAIT.
- M_WAIT: on dmem_rsp_valid, go to WB. Stores also wait for their ack.
- WB: for one cycle:
  - rf_w_en = dec_rd_w_en & ~dec_is_store.
  - pc_o <= next_pc.
  - instret_o <= instret_o + 1, wrapping modulo 2^64.
  - Then go to F_REQ.
- HALT: halt=1 and all request valids and rf_w_en are 0. PC and instret are frozen. Only rst leaves this state.
- Valid/ready rules:
  - Once a request valid is raised, it stays high with a stable address (and stable dmem_we) until the cycle ready is seen.
  - A response is accepted only in the matching WAIT state.
- Reset values:
  - state=F_REQ, pc_o=RESET_PC, inst_o=NOP_INST, instret_o=0, halt=0.
  - All request valids and rf_w_en are forced 0 while rst is high, gated combinationally.
- Reset mid-operation: asserting rst in any state immediately returns to the reset values. Any outstanding memory transaction is abandoned; memories must be reset together with the core.

## Timing
- Outputs are Moore decoded from state. No combinational path from ready/valid inputs to any output.
- Minimum latency, with ready asserted in the F_REQ cycle and the response in the next cycle:
  - Non-memory instruction: 5 cycles (F_REQ, F_WAIT, DEC, EXE, WB). The next F_REQ starts in cycle 6.
  - Load or store with zero-wait memory: 7 cycles.
- Each stall cycle of imem_req_ready, imem_rsp_valid, dmem_req_ready or dmem_rsp_valid adds exactly one cycle.
- pc_o and instret_o update on the clock edge that ends WB. imem_addr for the next fetch is the new PC.

## Test plan
- Reset with ready and responses held high: pc_o=0x80000000, inst_o=0x00000013, instret_o=0, state_o=0, imem_req_valid=1 only after rst falls.
- ALU instruction (addi, dec_rd_w_en=1), next_pc=0x80000004, zero-wait fetch: rf_w_en pulses in cycle 5, then pc_o=0x80000004, instret_o=1, imem_req_valid=1 in cycle 6.
- imem_req_ready held low 3 cycles: imem_req_valid stays 1 with imem_addr stable at 0x80000000. Retire occurs in cycle 8.
- Load with dmem_rsp_valid delayed 2 cycles: dmem_we=0, rf_w_en pulses once, total 9 cycles. Store: dmem_we=1, rf_w_en stays 0.
- ebreak in EXE: halt=1 and state_o=7 from the next cycle. No further requests for 20 cycles; instret_o is unchanged.
- rst pulsed while in M_WAIT: dmem_req_valid=0 and pc_o=0x80000000 immediately. Fetch restarts after rst falls.
